// File: rtl/contador_bcd_descendente.sv
// Cascaded NDIG-digit BCD down-counter with prescaler and terminal-zero pulse.
// Optional CONTADOR_AUTO_RELOAD_EN: reload the preset on reaching zero.
module contador_bcd_descendente #(
  parameter int NDIG = 3,
  parameter int DIV  = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              start,
  input  logic              pause,
  output logic [4*NDIG-1:0] q,
  output logic              running,
  output logic              zero,
  output logic              done_tick
);

  localparam int W  = 4 * NDIG;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [W-1:0]   r_q;
  logic [W-1:0]   w_q_nx;
  logic [W-1:0]   w_q_dec;
  logic [W-1:0]   w_load_clamp;
  logic [PW-1:0]  r_presc;
  logic [PW-1:0]  w_presc_nx;
  logic           r_done;
  logic           w_done_nx;
  logic           w_hold;
  logic           w_advance;
  logic           w_dec_tick;
  logic           w_last;
  logic           w_q_is_zero;
  logic           w_reload_ok;
  logic [W-1:0]   w_reload_val;

`ifdef CONTADOR_AUTO_RELOAD_EN
  logic [W-1:0]   r_reload;
  logic [W-1:0]   w_reload_nx;
`endif

  // Digits above 9 in the preset saturate at 9 so q stays valid BCD.
  always_comb begin
    w_load_clamp = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        w_load_clamp[4*i +: 4] = 4'd9;
      else
        w_load_clamp[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Borrow ripple: digit i steps only when all lower digits are 0.
  always_comb begin : dec_chain
    logic       b;
    logic [3:0] d;
    w_q_dec = '0;
    b       = 1'b1;
    d       = '0;
    for (int i = 0; i < NDIG; i++) begin
      d = r_q[4*i +: 4];
      if (b) begin
        if (d == 4'd0)
          d = 4'd9;
        else
          d = d - 4'd1;
      end
      w_q_dec[4*i +: 4] = d;
      b = b & (r_q[4*i +: 4] == 4'd0);
    end
  end

  assign w_q_is_zero = (r_q == '0);
  assign w_last      = (r_q == W'(1));

  // A start in RUN keeps counting, so it masks a simultaneous pause.
  assign w_hold     = pause & ~start;
  assign w_advance  = (r_state == S_RUN) & ~w_hold;
  assign w_dec_tick = w_advance & (r_presc == PMAX);

`ifdef CONTADOR_AUTO_RELOAD_EN
  assign w_reload_ok  = (r_reload != '0);
  assign w_reload_val = r_reload;
`else
  assign w_reload_ok  = 1'b0;
  assign w_reload_val = '0;
`endif

  // Next-state, next-count and prescaler decode; strobes in priority order.
  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_presc_nx = r_presc;
    w_done_nx  = 1'b0;
    if (soft_reset) begin
      w_state_nx = S_IDLE;
      w_q_nx     = '0;
      w_presc_nx = '0;
    end else if (load && (r_state != S_RUN)) begin
      w_state_nx = S_IDLE;
      w_q_nx     = w_load_clamp;
      w_presc_nx = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_q_is_zero) begin
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_hold) begin
            w_state_nx = S_PAUSE;
          end else if (w_dec_tick) begin
            w_presc_nx = '0;
            if (w_last) begin
              w_done_nx = 1'b1;
              if (w_reload_ok) begin
                w_q_nx = w_reload_val;
              end else begin
                w_q_nx     = '0;
                w_state_nx = S_DONE;
              end
            end else begin
              w_q_nx = w_q_dec;
            end
          end else begin
            w_presc_nx = r_presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (start)
            w_state_nx = S_RUN;
        end
        S_DONE: begin
          w_q_nx = '0;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  // State, count, prescaler and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_presc <= w_presc_nx;
      r_done  <= w_done_nx;
    end
  end

`ifdef CONTADOR_AUTO_RELOAD_EN
  // Reload value follows every accepted preset and every clear.
  always_comb begin
    w_reload_nx = r_reload;
    if (soft_reset)
      w_reload_nx = '0;
    else if (load && (r_state != S_RUN))
      w_reload_nx = w_load_clamp;
  end

  // Reload register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_reload <= '0;
    else
      r_reload <= w_reload_nx;
  end
`endif

  assign q         = r_q;
  assign running   = (r_state == S_RUN);
  assign zero      = w_q_is_zero;
  assign done_tick = r_done;

endmodule
